uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Parametrised multi-source transmit front end for the UART transmitter. Each byte source (keyboard ASCII, parser replies, debug) gets its own FIFO, so no byte is lost while the transmitter is busy. An arbiter drains the FIFOs one byte at a time using the transmitter's start/busy handshake. It sits between the byte producers and async_transmitter and replaces the direct, unbuffered keyboard-to-UART start path.

Parameters:
CHANNELS, 2, number of independent byte sources (1..8)
DEPTH, 16, entries per channel FIFO; power of two, at least 2
DATA_WIDTH, 8, bits per entry
ARB_MODE, 0, 0 = fixed priority (channel 0 highest), 1 = round-robin
ARM_TIMEOUT, 4, cycles to wait for txBusy to rise after txStart before abandoning the wait

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  reset, asynchronous, active-low
inValid  in  CHANNELS  per-channel push strobe; one byte per asserted cycle
inData  in  CHANNELS*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
inFull  out  CHANNELS  registered per-channel FIFO full flag
level  out  CHANNELS*(log2(DEPTH)+1)  registered per-channel occupancy count, 0..DEPTH
overflow  out  CHANNELS  sticky flag: a push to this channel was dropped
clearOverflow  in  1  synchronous clear of all overflow bits
txStart  out  1  one-cycle start pulse to the transmitter
txData  out  DATA_WIDTH  byte presented to the transmitter; held stable from txStart until return to IDLE
txBusy  in  1  transmitter busy flag

Behaviour:
- Reset (rst low, asynchronous):
  - all FIFOs empty, level = 0, inFull = 0, overflow = 0
  - txStart = 0, txData = 0, state = IDLE
  - round-robin pointer = CHANNELS-1, so channel 0 is granted first
- Reset mid-transfer discards all queued bytes. The transmitter may still finish a byte already started.
- Push rules:
  - A push to channel c is accepted if level[c] < DEPTH, or if the arbiter pops channel c in the same cycle.
  - Otherwise the byte is dropped and overflow[c] is set on that edge.
  - If clearOverflow and a new drop occur in the same cycle, overflow[c] stays set.
  - Pointers wrap modulo DEPTH.
  - level updates by +1, -1, or 0 (simultaneous push and pop).
- FSM states: IDLE, START, ARM, DRAIN.
  - IDLE: if txBusy = 0 and any level > 0, select a channel, pop its head into txData, go to START. Otherwise stay.
  - START: txStart = 1 for exactly this cycle, go to ARM.
  - ARM: if txBusy = 1, go to DRAIN. After ARM_TIMEOUT cycles without txBusy, go to IDLE (byte counted as sent).
  - DRAIN: wait for txBusy = 0, then go to IDLE.
- Selection rules:
  - ARB_MODE 0: lowest-index non-empty channel.
  - ARB_MODE 1: first non-empty channel scanning from pointer+1 with wrap. Pointer is set to the granted channel at pop.
- Latency: a byte pushed into an empty system on edge N is popped on edge N+1. txStart is high during the cycle after edge N+2.
- Minimum spacing between consecutive txStart pulses is 4 cycles, plus the transmitter's busy time.
- txBusy high in IDLE blocks issue; there is no preemption.
- An empty FIFO never pops. level never exceeds DEPTH or goes below 0.

Test Plan:
- Reset, then push 0x41 on channel 0 with txBusy held 0 -> txStart pulses once, 3 cycles after the push edge, with txData = 0x41; level[0] returns to 0.
- CHANNELS=2, ARB_MODE 0, push 0x10 and 0x20 on channels 0 and 1 in the same cycle; model busy for 10 cycles after each start -> txData sequence is 0x10 then 0x20.
- ARB_MODE 1, preload 3 bytes per channel (0xA0.., 0xB0..) -> transmit order A0 B0 A1 B1 A2 B2.
- Hold txBusy = 1, push 17 bytes into channel 0 (DEPTH 16) -> level[0] = 16, inFull[0] = 1, overflow[0] = 1; pulse clearOverflow -> overflow[0] = 0, queued data intact.
- Tie txBusy to 0 permanently -> after txStart the FSM spends ARM_TIMEOUT cycles in ARM, then returns to IDLE; the next byte is issued; no hang.
- Assert rst low mid-DRAIN with 5 bytes queued -> outputs go to reset values immediately (asynchronously); no txStart after release until a new push.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Multi-source UART transmit front end: one FIFO per byte source, drained one
// byte at a time into async_transmitter through its start/busy handshake.
module uart_tx_arbiter #(
    parameter int CHANNELS    = 2,
    parameter int DEPTH       = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ARB_MODE    = 0,
    parameter int ARM_TIMEOUT = 4,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            inValid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] inData,
    output logic [CHANNELS-1:0]            inFull,
    output logic [CHANNELS*LVL_W-1:0]      level,
    output logic [CHANNELS-1:0]            overflow,
    input  logic                           clearOverflow,
    output logic                           txStart,
    output logic [DATA_WIDTH-1:0]          txData,
    input  logic                           txBusy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = $clog2(ARM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_ARM   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      arm_cnt_q, arm_cnt_d;
    logic [CH_W-1:0]       rr_q, rr_d;
    logic                  tx_start_q, tx_start_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

    logic [PTR_W-1:0]      wr_ptr_q [CHANNELS];
    logic [PTR_W-1:0]      wr_ptr_d [CHANNELS];
    logic [PTR_W-1:0]      rd_ptr_q [CHANNELS];
    logic [PTR_W-1:0]      rd_ptr_d [CHANNELS];
    logic [LVL_W-1:0]      lvl_q    [CHANNELS];
    logic [LVL_W-1:0]      lvl_d    [CHANNELS];
    logic [CHANNELS-1:0]   full_q, full_d;
    logic [CHANNELS-1:0]   ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] mem_q    [CHANNELS][DEPTH];

    logic [CHANNELS-1:0]   nonempty_s;
    logic [CHANNELS-1:0]   push_s;
    logic [CHANNELS-1:0]   pop_s;
    logic                  any_s;
    logic [CH_W-1:0]       grant_s;

    // Scan position i of the arbiter: round-robin starts just after the last grant.
    function automatic int sel_idx(input logic [CH_W-1:0] rr, input int i);
        if (ARB_MODE == 1) begin
            return (int'(rr) + 1 + i) % CHANNELS;
        end else begin
            return i;
        end
    endfunction

    // Channel selection: first non-empty channel in scan order.
    always_comb begin
        any_s   = 1'b0;
        grant_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            nonempty_s[c] = (lvl_q[c] != '0);
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!any_s && nonempty_s[sel_idx(rr_q, i)]) begin
                any_s   = 1'b1;
                grant_s = CH_W'(sel_idx(rr_q, i));
            end else begin
                any_s   = any_s;
            end
        end
    end

    // Issue FSM: pop in IDLE, pulse start, wait for busy (bounded), wait for idle.
    always_comb begin
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        rr_d       = rr_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop_s      = '0;
        case (state_q)
            S_IDLE: begin
                if (!txBusy && any_s) begin
                    pop_s[grant_s] = 1'b1;
                    tx_data_d      = mem_q[grant_s][rd_ptr_q[grant_s]];
                    rr_d           = grant_s;
                    state_d        = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                tx_start_d = 1'b1;
                arm_cnt_d  = '0;
                state_d    = S_ARM;
            end
            S_ARM: begin
                if (txBusy) begin
                    state_d = S_DRAIN;
                end else if (arm_cnt_q == CNT_W'(ARM_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged; treat the byte as sent.
                    state_d = S_IDLE;
                end else begin
                    arm_cnt_d = arm_cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (!txBusy) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Per-channel FIFO bookkeeping; a full FIFO still accepts when popped this cycle.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            push_s[c]   = inValid[c] && ((lvl_q[c] != LVL_W'(DEPTH)) || pop_s[c]);
            wr_ptr_d[c] = wr_ptr_q[c] + (push_s[c] ? PTR_W'(1) : PTR_W'(0));
            rd_ptr_d[c] = rd_ptr_q[c] + (pop_s[c] ? PTR_W'(1) : PTR_W'(0));
            case ({push_s[c], pop_s[c]})
                2'b10:   lvl_d[c] = lvl_q[c] + LVL_W'(1);
                2'b01:   lvl_d[c] = lvl_q[c] - LVL_W'(1);
                default: lvl_d[c] = lvl_q[c];
            endcase
            full_d[c] = (lvl_d[c] == LVL_W'(DEPTH));
            ovf_d[c]  = (clearOverflow ? 1'b0 : ovf_q[c]) | (inValid[c] & ~push_s[c]);
        end
    end

    // State, pointer and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            arm_cnt_q  <= '0;
            rr_q       <= CH_W'(CHANNELS - 1);
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            full_q     <= '0;
            ovf_q      <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                lvl_q[c]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            rr_q       <= rr_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                lvl_q[c]    <= lvl_d[c];
            end
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (push_s[c]) begin
                mem_q[c][wr_ptr_q[c]] <= inData[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_level
        assign level[g*LVL_W +: LVL_W] = lvl_q[g];
    end

    assign inFull   = full_q;
    assign overflow = ovf_q;
    assign txStart  = tx_start_q;
    assign txData   = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a fixed-priority and a round-robin instance
// with a simple transmitter busy model driven from tasks.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [1:0]  v0 = 2'b00, v1 = 2'b00;
    logic [15:0] di0 = 16'h0000, di1 = 16'h0000;
    logic [1:0]  f0, f1, o0, o1;
    logic [9:0]  l0, l1;
    logic        c0 = 1'b0, c1 = 1'b0;
    logic        s0, s1;
    logic [7:0]  t0, t1;
    logic        b0 = 1'b0, b1 = 1'b0;

    int checks = 0;
    int errors = 0;

    int         cap_n;
    logic [7:0] cap_d [64];
    int         cap_t [64];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.CHANNELS(2), .DEPTH(16), .DATA_WIDTH(8), .ARB_MODE(0), .ARM_TIMEOUT(4)) dut0 (
        .clk(clk), .rst(rst), .inValid(v0), .inData(di0), .inFull(f0), .level(l0),
        .overflow(o0), .clearOverflow(c0), .txStart(s0), .txData(t0), .txBusy(b0)
    );

    uart_tx_arbiter #(.CHANNELS(2), .DEPTH(16), .DATA_WIDTH(8), .ARB_MODE(1), .ARM_TIMEOUT(4)) dut1 (
        .clk(clk), .rst(rst), .inValid(v1), .inData(di1), .inFull(f1), .level(l1),
        .overflow(o1), .clearOverflow(c1), .txStart(s1), .txData(t1), .txBusy(b1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        v0 = 2'b00; v1 = 2'b00; c0 = 1'b0; c1 = 1'b0; b0 = 1'b0; b1 = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        step();
    endtask

    // Runs a fixed number of cycles, records every txStart and models busy_len cycles of busy.
    task automatic tx_run(input int which, input int busy_len, input int cycles);
        int bcnt;
        bcnt  = 0;
        cap_n = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    if (which == 1) b1 = 1'b0; else b0 = 1'b0;
                end
            end
            if ((which == 0 && s0 === 1'b1) || (which == 1 && s1 === 1'b1)) begin
                if (cap_n < 64) begin
                    cap_d[cap_n] = (which == 1) ? t1 : t0;
                    cap_t[cap_n] = k;
                end
                cap_n++;
                if (busy_len > 0) begin
                    if (which == 1) b1 = 1'b1; else b0 = 1'b1;
                    bcnt = busy_len;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (s0 !== 1'b0)  begin errors++; $display("FAIL reset_start: got %b want 0", s0); end
        checks++; if (t0 !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", t0); end
        checks++; if (l0 !== 10'd0) begin errors++; $display("FAIL reset_level: got %h want 0", l0); end
        checks++; if (f0 !== 2'b00) begin errors++; $display("FAIL reset_full: got %b want 00", f0); end
        checks++; if (o0 !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b want 00", o0); end
        checks++; if (l1 !== 10'd0) begin errors++; $display("FAIL reset_level_rr: got %h want 0", l1); end
    endtask

    task automatic test_single_push();
        int extra;
        do_reset();
        v0 = 2'b01; di0 = 16'h0041;
        step();
        v0 = 2'b00;
        checks++; if (l0[4:0] !== 5'd1) begin errors++; $display("FAIL single_lvl_push: got %0d want 1", l0[4:0]); end
        checks++; if (s0 !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b want 0", s0); end
        step();
        checks++; if (l0[4:0] !== 5'd0) begin errors++; $display("FAIL single_lvl_pop: got %0d want 0", l0[4:0]); end
        checks++; if (t0 !== 8'h41) begin errors++; $display("FAIL single_data_pop: got %h want 41", t0); end
        checks++; if (s0 !== 1'b0) begin errors++; $display("FAIL single_start_n1: got %b want 0", s0); end
        step();
        checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL single_start_n2: got %b want 1", s0); end
        checks++; if (t0 !== 8'h41) begin errors++; $display("FAIL single_data_start: got %h want 41", t0); end
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (s0 === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL single_extra_pulses: got %0d want 0", extra); end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        v0 = 2'b11; di0 = 16'h2010;
        step();
        v0 = 2'b00;
        tx_run(0, 10, 80);
        checks++; if (cap_n != 2) begin errors++; $display("FAIL prio_count: got %0d want 2", cap_n); end
        checks++; if (cap_d[0] !== 8'h10) begin errors++; $display("FAIL prio_first: got %h want 10", cap_d[0]); end
        checks++; if (cap_d[1] !== 8'h20) begin errors++; $display("FAIL prio_second: got %h want 20", cap_d[1]); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_rr [6];
        exp_rr = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
        do_reset();
        b1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v1 = 2'b11;
            di1 = {8'hB0 + 8'(i), 8'hA0 + 8'(i)};
            step();
        end
        v1 = 2'b00;
        checks++; if (l1 !== {5'd3, 5'd3}) begin errors++; $display("FAIL rr_preload: got %h want 063", l1); end
        b1 = 1'b0;
        tx_run(1, 5, 120);
        checks++; if (cap_n != 6) begin errors++; $display("FAIL rr_count: got %0d want 6", cap_n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (cap_d[i] !== exp_rr[i]) begin
                errors++; $display("FAIL rr_order[%0d]: got %h want %h", i, cap_d[i], exp_rr[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        b0 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            v0 = 2'b01; di0 = {8'h00, 8'(i)};
            step();
        end
        v0 = 2'b00;
        checks++; if (l0[4:0] !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d want 16", l0[4:0]); end
        checks++; if (f0 !== 2'b01) begin errors++; $display("FAIL ovf_full: got %b want 01", f0); end
        checks++; if (o0 !== 2'b01) begin errors++; $display("FAIL ovf_flag: got %b want 01", o0); end
        c0 = 1'b1;
        step();
        c0 = 1'b0;
        checks++; if (o0 !== 2'b00) begin errors++; $display("FAIL ovf_clear: got %b want 00", o0); end
        checks++; if (l0[4:0] !== 5'd16) begin errors++; $display("FAIL ovf_level_kept: got %0d want 16", l0[4:0]); end
        b0 = 1'b0;
        tx_run(0, 3, 220);
        checks++; if (cap_n != 16) begin errors++; $display("FAIL ovf_drain_count: got %0d want 16", cap_n); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (cap_d[i] !== 8'(i)) begin
                errors++; $display("FAIL ovf_data[%0d]: got %h want %h", i, cap_d[i], 8'(i));
            end
        end
        checks++; if (l0[4:0] !== 5'd0) begin errors++; $display("FAIL ovf_level_end: got %0d want 0", l0[4:0]); end
    endtask

    task automatic test_arm_timeout();
        do_reset();
        b0 = 1'b0;
        v0 = 2'b01; di0 = 16'h0051;
        step();
        di0 = 16'h0052;
        step();
        v0 = 2'b00;
        tx_run(0, 0, 24);
        checks++; if (cap_n != 2) begin errors++; $display("FAIL timeout_count: got %0d want 2", cap_n); end
        checks++; if (cap_t[0] != 0) begin errors++; $display("FAIL timeout_first_at: got %0d want 0", cap_t[0]); end
        checks++; if (cap_t[1] - cap_t[0] != 6) begin errors++; $display("FAIL timeout_spacing: got %0d want 6", cap_t[1] - cap_t[0]); end
        checks++; if (cap_d[0] !== 8'h51) begin errors++; $display("FAIL timeout_data0: got %h want 51", cap_d[0]); end
        checks++; if (cap_d[1] !== 8'h52) begin errors++; $display("FAIL timeout_data1: got %h want 52", cap_d[1]); end
    endtask

    task automatic test_reset_mid_drain();
        int seen;
        int pulses;
        do_reset();
        b0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            v0 = 2'b01; di0 = {8'h00, 8'h60 + 8'(i)};
            step();
        end
        v0 = 2'b00;
        b0 = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            step();
            if (s0 === 1'b1) begin
                seen = 1;
                b0 = 1'b1;
            end
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL mid_start_seen: got %0d want 1", seen); end
        step();
        step();
        checks++; if (l0[4:0] !== 5'd5) begin errors++; $display("FAIL mid_queued: got %0d want 5", l0[4:0]); end
        #2 rst = 1'b0;
        #1;
        checks++; if (t0 !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h want 00", t0); end
        checks++; if (l0 !== 10'd0) begin errors++; $display("FAIL mid_rst_level: got %h want 0", l0); end
        checks++; if (s0 !== 1'b0 || f0 !== 2'b00 || o0 !== 2'b00) begin
            errors++; $display("FAIL mid_rst_flags: got start=%b full=%b ovf=%b want 0 00 00", s0, f0, o0);
        end
        @(negedge clk);
        rst = 1'b1;
        b0 = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (s0 === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL mid_no_start: got %0d want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fixed_priority();
        test_round_robin();
        test_overflow();
        test_arm_timeout();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
